// File: rtl/core_seq_if.sv
// Instruction- and data-memory handshake bundle between the sequencer (master)
// and the memory side (slave).
interface core_seq_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_ack, imem_rdata, dmem_ack
    );
    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_ack, imem_rdata, dmem_ack
    );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control FSM: owns PC and instret, runs the memory handshakes
// and sequences decode/ALU/memory/register-file strobes per opcode.
module core_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    core_seq_if.master  mem,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    input  logic        branch_taken,
    output logic        alu_en,
    output logic        rf_we,
    output logic [31:0] pc,
    output logic [31:0] instret,
    output logic        trap,
    output logic [1:0]  trap_cause
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    // Count of prior no-ack cycles at which the current no-ack cycle times out.
    localparam logic [7:0] TO_LAST   = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_TRAP} state_e;

    state_e      state_q;
    logic [31:0] pc_q, instr_q, instret_q;
    logic [7:0]  cnt_q;
    logic        imem_req_q, instr_valid_q, alu_en_q, dmem_req_q, dmem_we_q, rf_we_q, trap_q;
    logic [1:0]  cause_q;

    logic [6:0]  opc;
    logic        legal, is_mem, is_store, writes_rd;
    logic [31:0] npc_d;
    logic        npc_mis;

    assign opc = instr_q[6:0];

    always_comb begin
        legal     = 1'b1;
        is_mem    = 1'b0;
        is_store  = 1'b0;
        writes_rd = 1'b0;
        case (opc)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_OPIMM, OP_OP: writes_rd = 1'b1;
            OP_LOAD:             begin is_mem = 1'b1; writes_rd = 1'b1; end
            OP_STORE:            begin is_mem = 1'b1; is_store  = 1'b1; end
            OP_BRANCH, OP_FENCE: ;
            default:             legal = 1'b0;
        endcase
    end

    always_comb begin
        npc_d = pc_q + 32'd4;
        if (opc == OP_JAL || (opc == OP_BRANCH && branch_taken))
            npc_d = pc_q + imm;
        else if (opc == OP_JALR)
            npc_d = (rs1_data + imm) & ~32'h1;
        npc_mis = |npc_d[1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instret_q     <= '0;
            cnt_q         <= '0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            alu_en_q      <= 1'b0;
            dmem_req_q    <= 1'b0;
            dmem_we_q     <= 1'b0;
            rf_we_q       <= 1'b0;
            trap_q        <= 1'b0;
            cause_q       <= 2'd0;
        end else begin
            instr_valid_q <= 1'b0;
            alu_en_q      <= 1'b0;
            rf_we_q       <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    // First FETCH after reset only raises the request.
                    if (!imem_req_q) begin
                        imem_req_q <= 1'b1;
                        cnt_q      <= '0;
                    end else if (mem.imem_ack) begin
                        instr_q       <= mem.imem_rdata;
                        imem_req_q    <= 1'b0;
                        instr_valid_q <= 1'b1;
                        state_q       <= S_DECODE;
                    end else if (cnt_q == TO_LAST) begin
                        imem_req_q <= 1'b0;
                        trap_q     <= 1'b1;
                        cause_q    <= 2'd2;
                        state_q    <= S_TRAP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_DECODE: begin
                    if (!legal) begin
                        trap_q  <= 1'b1;
                        cause_q <= 2'd0;
                        state_q <= S_TRAP;
                    end else begin
                        alu_en_q <= 1'b1;
                        state_q  <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (is_mem) begin
                        dmem_req_q <= 1'b1;
                        dmem_we_q  <= is_store;
                        cnt_q      <= '0;
                        state_q    <= S_MEM;
                    end else begin
                        rf_we_q <= writes_rd;
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem.dmem_ack) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        rf_we_q    <= writes_rd;
                        state_q    <= S_WB;
                    end else if (cnt_q == TO_LAST) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        trap_q     <= 1'b1;
                        cause_q    <= 2'd3;
                        state_q    <= S_TRAP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_WB: begin
                    if (npc_mis) begin
                        trap_q  <= 1'b1;
                        cause_q <= 2'd1;
                        state_q <= S_TRAP;
                    end else begin
                        pc_q       <= npc_d;
                        instret_q  <= instret_q + 32'd1;
                        imem_req_q <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= S_FETCH;
                    end
                end
                S_TRAP:  ;
                default: state_q <= S_TRAP;
            endcase
        end
    end

    assign mem.imem_req  = imem_req_q;
    assign mem.imem_addr = pc_q;
    assign mem.dmem_req  = dmem_req_q;
    assign mem.dmem_we   = dmem_we_q;
    assign instr         = instr_q;
    assign instr_valid   = instr_valid_q;
    assign alu_en        = alu_en_q;
    // A JALR target is only known from rs1_data in WRITEBACK, so a misaligned
    // target suppresses the already-registered write strobe.
    assign rf_we         = rf_we_q & ~((state_q == S_WB) & npc_mis);
    assign pc            = pc_q;
    assign instret       = instret_q;
    assign trap          = trap_q;
    assign trap_cause    = cause_q;
endmodule

// File: tb/tb_core_sequencer.sv
// Directed cycle-accurate bench for core_sequencer with MEM_TIMEOUT=4.
module tb_core_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr, imm, rs1_data, pc, instret;
    logic        instr_valid, branch_taken, alu_en, rf_we, trap;
    logic [1:0]  trap_cause;
    int          tests = 0;
    int          fails = 0;

    core_seq_if bus ();

    core_sequencer #(.RESET_PC(32'h0), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .mem(bus.master),
        .instr(instr), .instr_valid(instr_valid),
        .imm(imm), .rs1_data(rs1_data), .branch_taken(branch_taken),
        .alu_en(alu_en), .rf_we(rf_we), .pc(pc), .instret(instret),
        .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] ADDI  = 32'h0050_0093;
    localparam logic [31:0] LW    = 32'h0000_A103;
    localparam logic [31:0] SW    = 32'h0020_A023;
    localparam logic [31:0] JAL   = 32'h0000_006F;
    localparam logic [31:0] JALR  = 32'h0000_8067;
    localparam logic [31:0] BEQ   = 32'h0000_0063;
    localparam logic [31:0] FENCE = 32'h0000_000F;
    localparam logic [31:0] ECALL = 32'h0000_0073;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called in a cycle with imem_req=1; returns in the DECODE cycle.
    task automatic do_fetch(input logic [31:0] w, input int waits);
        bus.imem_ack = 1'b0;
        for (int i = 0; i < waits; i++) step();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = w;
        step();
        bus.imem_ack = 1'b0;
    endtask

    // Full non-memory instruction from FETCH back to FETCH (or TRAP).
    task automatic run_nonmem(input string tag, input logic [31:0] w, input logic [31:0] im,
                              input logic [31:0] rs1, input logic bt, input logic exp_we);
        do_fetch(w, 0);
        imm = im; rs1_data = rs1; branch_taken = bt;
        step();
        step();
        chk({tag, "_rf_we"}, {31'd0, rf_we}, {31'd0, exp_we});
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.dmem_ack = 1'b0;
        imm = '0; rs1_data = '0; branch_taken = 1'b0;
        step();
        step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instret", instret, 32'h0);
        chk("rst_trap", {31'd0, trap}, 32'd0);
        chk("rst_cause", {30'd0, trap_cause}, 32'd0);
        chk("rst_strobes", {27'd0, bus.imem_req, instr_valid, alu_en, bus.dmem_req, rf_we}, 32'd0);

        // ADDI, zero wait: req, valid, alu, rf_we on cycles 1..4
        rst = 1'b0;
        step();
        chk("addi_c1_req", {31'd0, bus.imem_req}, 32'd1);
        chk("addi_addr", bus.imem_addr, 32'h0);
        do_fetch(ADDI, 0);
        chk("addi_c2_valid", {30'd0, instr_valid, bus.imem_req}, 32'b10);
        chk("addi_instr", instr, ADDI);
        imm = 32'd5;
        step();
        chk("addi_c3_alu", {30'd0, alu_en, instr_valid}, 32'b10);
        step();
        chk("addi_c4_rfwe", {30'd0, rf_we, alu_en}, 32'b10);
        step();
        chk("addi_pc", pc, 32'h4);
        chk("addi_instret", instret, 32'd1);
        chk("addi_next_req", {31'd0, bus.imem_req}, 32'd1);

        // LW with dmem ack on the 4th request cycle
        do_fetch(LW, 0);
        imm = 32'h0;
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("lw_mem%0d_req_we", i), {30'd0, bus.dmem_req, bus.dmem_we}, 32'b10);
            chk($sformatf("lw_mem%0d_rfwe", i), {31'd0, rf_we}, 32'd0);
            bus.dmem_ack = (i == 3);
            step();
        end
        bus.dmem_ack = 1'b0;
        chk("lw_wb", {30'd0, rf_we, bus.dmem_req}, 32'b10);
        step();
        chk("lw_pc", pc, 32'h8);
        chk("lw_instret", instret, 32'd2);

        // JAL 0x8 -> 0x100, then branches around 0x100
        run_nonmem("jal", JAL, 32'hF8, 32'h0, 1'b0, 1'b1);
        chk("jal_pc", pc, 32'h100);
        run_nonmem("beq_t", BEQ, 32'hFFFF_FFF8, 32'h0, 1'b1, 1'b0);
        chk("beq_t_pc", pc, 32'hF8);
        run_nonmem("beq_nt", BEQ, 32'hFFFF_FFF8, 32'h0, 1'b0, 1'b0);
        chk("beq_nt_pc", pc, 32'hFC);
        run_nonmem("fence", FENCE, 32'h40, 32'h0, 1'b1, 1'b0);
        chk("fence_pc", pc, 32'h100);
        run_nonmem("beq_nt2", BEQ, 32'hFFFF_FFF8, 32'h0, 1'b0, 1'b0);
        chk("beq_nt2_pc", pc, 32'h104);
        chk("beq_instret", instret, 32'd7);

        // JALR clears bit 0; JAL to a misaligned target traps without retiring
        run_nonmem("jalr", JALR, 32'h0, 32'h205, 1'b0, 1'b1);
        chk("jalr_pc", pc, 32'h204);
        run_nonmem("jal_mis", JAL, 32'h6, 32'h0, 1'b0, 1'b0);
        chk("jal_mis_trap", {31'd0, trap}, 32'd1);
        chk("jal_mis_cause", {30'd0, trap_cause}, 32'd1);
        chk("jal_mis_pc", pc, 32'h204);
        chk("jal_mis_instret", instret, 32'd8);
        step();
        chk("jal_mis_req", {31'd0, bus.imem_req}, 32'd0);

        // ECALL is illegal: trap cause 0, held for 20 cycles
        do_reset();
        do_fetch(ECALL, 0);
        step();
        chk("ecall_trap", {30'd0, trap, alu_en}, 32'b10);
        chk("ecall_cause", {30'd0, trap_cause}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("ecall_hold%0d", i),
                {26'd0, trap, trap_cause, bus.imem_req, bus.dmem_req, rf_we}, 32'b100000);
        end
        rst = 1'b1;
        step();
        chk("ecall_rst_pc", pc, 32'h0);
        chk("ecall_rst_trap", {31'd0, trap}, 32'd0);

        // imem never acks: trap cause 2 after 4 wait cycles
        rst = 1'b0;
        step();
        bus.imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("ito_pre", {30'd0, trap, bus.imem_req}, 32'b01);
        step();
        chk("ito_trap", {30'd0, trap, bus.imem_req}, 32'b10);
        chk("ito_cause", {30'd0, trap_cause}, 32'd2);

        // ack on the cycle that would otherwise time out wins
        do_reset();
        do_fetch(ADDI, 3);
        chk("iack_edge", {30'd0, trap, instr_valid}, 32'b01);
        step();
        step();
        step();
        chk("iack_edge_pc", pc, 32'h4);

        // SW zero wait: dmem_we=1, no rf write
        do_fetch(SW, 0);
        step();
        step();
        chk("sw_mem", {30'd0, bus.dmem_req, bus.dmem_we}, 32'b11);
        bus.dmem_ack = 1'b1;
        step();
        bus.dmem_ack = 1'b0;
        chk("sw_wb", {29'd0, rf_we, bus.dmem_req, bus.dmem_we}, 32'd0);
        step();
        chk("sw_pc", pc, 32'h8);

        // reset in the middle of MEM abandons the access
        do_fetch(LW, 0);
        step();
        step();
        chk("mrst_mem", {31'd0, bus.dmem_req}, 32'd1);
        rst = 1'b1;
        step();
        chk("mrst_req", {30'd0, bus.dmem_req, bus.imem_req}, 32'd0);
        chk("mrst_pc", pc, 32'h0);
        chk("mrst_instret", instret, 32'd0);
        rst = 1'b0;
        step();
        chk("mrst_fetch", {31'd0, bus.imem_req}, 32'd1);
        run_nonmem("mrst_addi", ADDI, 32'd5, 32'h0, 1'b0, 1'b1);
        chk("mrst_addi_pc", pc, 32'h4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
